// File: rtl/udp_tx_hdr_to_stream_pkg.sv
// Purpose : shared UDP TX types (header layout, tracker stats) and the header-to-stream FSM states.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package udp_tx_hdr_to_stream_pkg;

    localparam int UDP_HDR_BYTES   = 8;
    localparam int UDP_HDR_W       = 64;
    localparam int TRACKER_STATS_W = 64;

    // Field order matches wire order: src_port is the first byte pair on the wire.
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;

    typedef struct packed {
        logic [31:0] tx_cycle;
        logic [31:0] seq_num;
    } tracker_stats_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_MID,
        ST_DRAIN,
        ST_HDR_ONLY
    } tx_state_e;

endpackage

// File: rtl/udp_tx_hdr_to_stream_ctrl.sv
// Purpose : sequencing FSM and all handshakes for the UDP header prepender.
// Latency : data handshakes are combinational pass-through in FIRST/MID; meta valid 1 cycle after header accept.
// Backpressure: src_data_rdy follows dst_data_rdy; a new header waits for the last output word and the metadata handshake.
// Ports: clk/rst; header, payload and meta handshake inputs; hdr_only_i/pad_ge_hdr_i decode hints from the datapath;
//        state_o plus accept strobes (hdr_acc_o, data_acc_o) that drive the datapath registers.
module udp_tx_hdr_to_stream_ctrl
    import udp_tx_hdr_to_stream_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      src_hdr_val_i,
    input  logic      hdr_only_i,
    input  logic      src_data_val_i,
    input  logic      src_data_last_i,
    input  logic      pad_ge_hdr_i,
    input  logic      dst_data_rdy_i,
    input  logic      dst_meta_rdy_i,
    output tx_state_e state_o,
    output logic      src_hdr_rdy_o,
    output logic      src_data_rdy_o,
    output logic      dst_data_val_o,
    output logic      dst_meta_val_o,
    output logic      hdr_acc_o,
    output logic      data_acc_o
);

    tx_state_e state_q, state_d;
    logic      meta_pending_q, meta_pending_d;

    assign state_o        = state_q;
    assign dst_meta_val_o = meta_pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            meta_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            meta_pending_q <= meta_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        meta_pending_d = meta_pending_q;
        src_hdr_rdy_o  = 1'b0;
        src_data_rdy_o = 1'b0;
        dst_data_val_o = 1'b0;
        hdr_acc_o      = 1'b0;
        data_acc_o     = 1'b0;

        // Metadata drains independently of the data stream.
        if (meta_pending_q && dst_meta_rdy_i) begin
            meta_pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Gated by rst so the ready only rises once reset has released.
                src_hdr_rdy_o = !meta_pending_q && !rst;
                if (src_hdr_val_i && src_hdr_rdy_o) begin
                    hdr_acc_o      = 1'b1;
                    meta_pending_d = 1'b1;
                    state_d        = hdr_only_i ? ST_HDR_ONLY : ST_FIRST;
                end
            end
            ST_FIRST, ST_MID: begin
                src_data_rdy_o = dst_data_rdy_i && !rst;
                dst_data_val_o = src_data_val_i && !rst;
                if (src_data_val_i && src_data_rdy_o) begin
                    data_acc_o = 1'b1;
                    if (src_data_last_i) begin
                        // Fewer than 8 pad bytes: the shifted-out tail needs one more word.
                        state_d = pad_ge_hdr_i ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = ST_MID;
                    end
                end
            end
            ST_DRAIN, ST_HDR_ONLY: begin
                dst_data_val_o = !rst;
                if (dst_data_rdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/udp_tx_hdr_to_stream.sv
// Purpose : prepend the 8-byte UDP header to a byte-packed payload stream and emit IP TX metadata separately.
// Latency : 0 cycles data (combinational) in FIRST/MID, +1 drain word when the tail spills; metadata 1 cycle after header accept.
// Backpressure: dst_data_rdy passes straight to src_data_rdy; outputs held stable while stalled; meta waits on dst_meta_rdy.
// Ports: clk/rst (sync, active-high); src_hdr_* header in; src_data_* payload in (byte 0 at MSB, padbytes = invalid
//        low bytes on last word); dst_meta_* metadata out; dst_data_* packet out; length_err sticky length mismatch.
// Build option: define UDP_TX_HDR_TO_STREAM_LEN_CHECK_EN to enable the payload byte counter behind length_err.
// DATA_W must be a multiple of 64 and at least 128.
module udp_tx_hdr_to_stream
    import udp_tx_hdr_to_stream_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int DATA_BYTES = DATA_W / 8,
    parameter int PADBYTES_W = $clog2(DATA_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      src_hdr_val,
    output logic                      src_hdr_rdy,
    input  logic [31:0]               src_src_ip,
    input  logic [31:0]               src_dst_ip,
    input  udp_pkt_hdr                src_udp_hdr,
    input  tracker_stats_struct       src_timestamp,
    input  logic                      src_data_val,
    output logic                      src_data_rdy,
    input  logic [DATA_W-1:0]         src_data,
    input  logic                      src_data_last,
    input  logic [PADBYTES_W-1:0]     src_data_padbytes,
    output logic                      dst_meta_val,
    input  logic                      dst_meta_rdy,
    output logic [31:0]               dst_meta_src_ip,
    output logic [31:0]               dst_meta_dst_ip,
    output logic [15:0]               dst_meta_udp_len,
    output tracker_stats_struct       dst_meta_timestamp,
    output logic                      dst_data_val,
    input  logic                      dst_data_rdy,
    output logic [DATA_W-1:0]         dst_data,
    output logic                      dst_data_last,
    output logic [PADBYTES_W-1:0]     dst_data_padbytes,
    output logic                      length_err
);

    localparam logic [PADBYTES_W:0] HDR_B  = (PADBYTES_W+1)'(UDP_HDR_BYTES);
    localparam logic [PADBYTES_W:0] WORD_B = (PADBYTES_W+1)'(DATA_BYTES);

    tx_state_e           state;
    logic                hdr_acc;
    logic                data_acc;
    logic                hdr_only;
    logic                pad_ge_hdr;

    udp_pkt_hdr          hdr_q;
    logic [31:0]         src_ip_q;
    logic [31:0]         dst_ip_q;
    tracker_stats_struct ts_q;
    logic [UDP_HDR_W-1:0]  carry_q;
    logic [PADBYTES_W-1:0] drain_pad_q;

    logic [DATA_W-1:0]   in_keep;
    logic [DATA_W-1:0]   in_dat;
    logic [PADBYTES_W:0] pad_ext;
    logic [DATA_W-1:0]   out_dat;
    logic                out_last;
    logic [PADBYTES_W:0] out_pad;

    assign hdr_only   = (src_udp_hdr.length <= 16'(UDP_HDR_BYTES));
    assign pad_ext    = {1'b0, src_data_padbytes};
    assign pad_ge_hdr = (pad_ext >= HDR_B);

    udp_tx_hdr_to_stream_ctrl u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .src_hdr_val_i   (src_hdr_val),
        .hdr_only_i      (hdr_only),
        .src_data_val_i  (src_data_val),
        .src_data_last_i (src_data_last),
        .pad_ge_hdr_i    (pad_ge_hdr),
        .dst_data_rdy_i  (dst_data_rdy),
        .dst_meta_rdy_i  (dst_meta_rdy),
        .state_o         (state),
        .src_hdr_rdy_o   (src_hdr_rdy),
        .src_data_rdy_o  (src_data_rdy),
        .dst_data_val_o  (dst_data_val),
        .dst_meta_val_o  (dst_meta_val),
        .hdr_acc_o       (hdr_acc),
        .data_acc_o      (data_acc)
    );

    // Zero the invalid tail bytes of the last word up front, so both the shifted
    // output and the carried tail have clean zero padding.
    always_comb begin
        in_keep = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            in_keep[8*b +: 8] = (!src_data_last || b >= int'(src_data_padbytes)) ? 8'hFF : 8'h00;
        end
    end
    assign in_dat = src_data & in_keep;

    always_comb begin
        out_dat  = '0;
        out_last = 1'b0;
        out_pad  = '0;
        case (state)
            ST_FIRST, ST_MID: begin
                out_dat = (state == ST_FIRST) ? {hdr_q, in_dat[DATA_W-1:UDP_HDR_W]}
                                              : {carry_q, in_dat[DATA_W-1:UDP_HDR_W]};
                if (src_data_last && pad_ge_hdr) begin
                    out_last = 1'b1;
                    out_pad  = pad_ext - HDR_B;
                end
            end
            ST_DRAIN: begin
                out_dat  = {carry_q, {(DATA_W-UDP_HDR_W){1'b0}}};
                out_last = 1'b1;
                out_pad  = WORD_B - HDR_B + {1'b0, drain_pad_q};
            end
            ST_HDR_ONLY: begin
                out_dat  = {hdr_q, {(DATA_W-UDP_HDR_W){1'b0}}};
                out_last = 1'b1;
                out_pad  = WORD_B - HDR_B;
            end
            default: ;
        endcase
    end

    // Idle output lanes read as zero; this also yields the reset values.
    assign dst_data          = dst_data_val ? out_dat : '0;
    assign dst_data_last     = dst_data_val && out_last;
    assign dst_data_padbytes = dst_data_val ? out_pad[PADBYTES_W-1:0] : '0;

    assign dst_meta_src_ip    = src_ip_q;
    assign dst_meta_dst_ip    = dst_ip_q;
    assign dst_meta_udp_len   = hdr_q.length;
    assign dst_meta_timestamp = ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q       <= '0;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            ts_q        <= '0;
            carry_q     <= '0;
            drain_pad_q <= '0;
        end else begin
            if (hdr_acc) begin
                hdr_q    <= src_udp_hdr;
                src_ip_q <= src_src_ip;
                dst_ip_q <= src_dst_ip;
                ts_q     <= src_timestamp;
            end
            if (data_acc) begin
                carry_q <= in_dat[UDP_HDR_W-1:0];
                if (src_data_last && !pad_ge_hdr) begin
                    drain_pad_q <= src_data_padbytes;
                end
            end
        end
    end

`ifdef UDP_TX_HDR_TO_STREAM_LEN_CHECK_EN
    logic [15:0] byte_cnt_q;
    logic [15:0] byte_cnt_d;
    logic [15:0] word_bytes;
    logic        len_err_q;

    assign word_bytes = src_data_last ? (16'(DATA_BYTES) - 16'(src_data_padbytes)) : 16'(DATA_BYTES);
    assign byte_cnt_d = byte_cnt_q + word_bytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            if (hdr_acc) begin
                byte_cnt_q <= '0;
                if (src_udp_hdr.length < 16'(UDP_HDR_BYTES)) begin
                    len_err_q <= 1'b1;
                end
            end
            if (data_acc) begin
                byte_cnt_q <= byte_cnt_d;
                if (src_data_last && (byte_cnt_d != hdr_q.length - 16'(UDP_HDR_BYTES))) begin
                    len_err_q <= 1'b1;
                end
            end
        end
    end
    assign length_err = len_err_q;
`else
    assign length_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_hdr_to_stream.sv
module tb_udp_tx_hdr_to_stream;
    import udp_tx_hdr_to_stream_pkg::*;

    localparam int DW = 512;
    localparam int DB = 64;
    localparam int PW = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                src_hdr_val;
    logic                src_hdr_rdy;
    logic [31:0]         src_src_ip;
    logic [31:0]         src_dst_ip;
    udp_pkt_hdr          src_udp_hdr;
    tracker_stats_struct src_timestamp;
    logic                src_data_val;
    logic                src_data_rdy;
    logic [DW-1:0]       src_data;
    logic                src_data_last;
    logic [PW-1:0]       src_data_padbytes;
    logic                dst_meta_val;
    logic                dst_meta_rdy;
    logic [31:0]         dst_meta_src_ip;
    logic [31:0]         dst_meta_dst_ip;
    logic [15:0]         dst_meta_udp_len;
    tracker_stats_struct dst_meta_timestamp;
    logic                dst_data_val;
    logic                dst_data_rdy;
    logic [DW-1:0]       dst_data;
    logic                dst_data_last;
    logic [PW-1:0]       dst_data_padbytes;
    logic                length_err;

    always #5 clk = ~clk;

    udp_tx_hdr_to_stream #(.DATA_W(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .src_hdr_val        (src_hdr_val),
        .src_hdr_rdy        (src_hdr_rdy),
        .src_src_ip         (src_src_ip),
        .src_dst_ip         (src_dst_ip),
        .src_udp_hdr        (src_udp_hdr),
        .src_timestamp      (src_timestamp),
        .src_data_val       (src_data_val),
        .src_data_rdy       (src_data_rdy),
        .src_data           (src_data),
        .src_data_last      (src_data_last),
        .src_data_padbytes  (src_data_padbytes),
        .dst_meta_val       (dst_meta_val),
        .dst_meta_rdy       (dst_meta_rdy),
        .dst_meta_src_ip    (dst_meta_src_ip),
        .dst_meta_dst_ip    (dst_meta_dst_ip),
        .dst_meta_udp_len   (dst_meta_udp_len),
        .dst_meta_timestamp (dst_meta_timestamp),
        .dst_data_val       (dst_data_val),
        .dst_data_rdy       (dst_data_rdy),
        .dst_data           (dst_data),
        .dst_data_last      (dst_data_last),
        .dst_data_padbytes  (dst_data_padbytes),
        .length_err         (length_err)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic [PW-1:0] pad;
    } word_t;

    typedef struct packed {
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] len;
        logic [63:0] ts;
    } meta_t;

    word_t exp_q[$];
    meta_t meta_q[$];
    word_t w_got;
    meta_t m_got;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hdr    = 0;
    int n_meta   = 0;
    int n_last   = 0;
    int n_words  = 0;
    int n_dacc   = 0;
    int last_pad_seen = -1;
    bit bp_en = 1'b0;

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pay_byte(input int pkt, input int idx);
        return 8'(pkt * 37 + idx * 5 + 1);
    endfunction

    // Monitor / scoreboard: compares every handshake against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (dst_meta_val && dst_meta_rdy) begin
                if (meta_q.size() == 0) begin
                    check_i("meta_unexpected", 1, 0);
                end else begin
                    m_got = meta_q.pop_front();
                    check_w("meta_src_ip", DW'(dst_meta_src_ip), DW'(m_got.sip));
                    check_w("meta_dst_ip", DW'(dst_meta_dst_ip), DW'(m_got.dip));
                    check_i("meta_udp_len", int'(dst_meta_udp_len), int'(m_got.len));
                    check_w("meta_ts", DW'(dst_meta_timestamp), DW'(m_got.ts));
                end
                n_meta++;
            end
            if (dst_data_val && dst_data_rdy) begin
                if (exp_q.size() == 0) begin
                    check_i("data_unexpected", 1, 0);
                end else begin
                    w_got = exp_q.pop_front();
                    check_w("data_word", dst_data, w_got.dat);
                    check_i("data_last", int'(dst_data_last), int'(w_got.last));
                    check_i("data_pad", int'(dst_data_padbytes), int'(w_got.pad));
                end
                if (dst_data_last) begin
                    n_last++;
                    last_pad_seen = int'(dst_data_padbytes);
                end
                n_words++;
            end
            if (src_data_val && src_data_rdy) n_dacc++;
            if (src_hdr_val && src_hdr_rdy) begin
                check_i("hdr_before_meta", n_meta, n_hdr);
                check_i("hdr_before_last", n_last, n_hdr);
                n_hdr++;
            end
        end
    end

    // Output backpressure.
    initial begin
        dst_data_rdy = 1'b1;
        dst_meta_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_data_rdy = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            dst_meta_rdy = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Queue expectations, then drive the header and up to max_words payload words.
    task automatic send_pkt(input int pkt, input int hdr_len, input int pay_len, input bit gaps, input int max_words);
        logic [7:0]    q[$];
        logic [63:0]   h;
        word_t         w;
        meta_t         m;
        logic [DW-1:0] d;
        int            n, nw, nin, t;

        h = {16'(pkt + 1000), 16'(pkt + 2000), 16'(hdr_len), 16'(pkt * 3)};
        m.sip = 32'hC0A8_0000 + 32'(pkt);
        m.dip = 32'h0A00_0000 + 32'(pkt);
        m.len = 16'(hdr_len);
        m.ts  = {32'(pkt), 32'hABCD_0000 + 32'(pkt)};
        meta_q.push_back(m);

        for (int i = 0; i < 8; i++) q.push_back(h[63-8*i -: 8]);
        for (int k = 0; k < pay_len; k++) q.push_back(pay_byte(pkt, k));
        n  = q.size();
        nw = (n + DB - 1) / DB;
        for (int wi = 0; wi < nw; wi++) begin
            w.dat = '0;
            for (int b = 0; b < DB; b++) begin
                if (wi * DB + b < n) w.dat[DW-1-8*b -: 8] = q[wi*DB+b];
            end
            w.last = (wi == nw - 1);
            w.pad  = w.last ? PW'(nw * DB - n) : '0;
            exp_q.push_back(w);
        end

        src_udp_hdr   = h;
        src_src_ip    = m.sip;
        src_dst_ip    = m.dip;
        src_timestamp = m.ts;
        src_hdr_val   = 1'b1;
        t = 0;
        @(negedge clk);
        while (!src_hdr_rdy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!src_hdr_rdy) check_i("hdr_timeout", 0, 1);
        @(posedge clk);
        #1;
        src_hdr_val = 1'b0;

        nin = (pay_len + DB - 1) / DB;
        for (int wi = 0; wi < nin && wi < max_words; wi++) begin
            if (gaps) begin
                src_data_val = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int b = 0; b < DB; b++) begin
                d[DW-1-8*b -: 8] = (wi * DB + b < pay_len) ? pay_byte(pkt, wi * DB + b) : 8'hEE;
            end
            src_data          = d;
            src_data_last     = (wi == nin - 1);
            src_data_padbytes = (wi == nin - 1) ? PW'(nin * DB - pay_len) : '0;
            src_data_val      = 1'b1;
            t = 0;
            @(negedge clk);
            while (!src_data_rdy && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!src_data_rdy) check_i("data_timeout", 0, 1);
            @(posedge clk);
            #1;
            src_data_val  = 1'b0;
            src_data_last = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || meta_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check_i("drain_timeout", exp_q.size() + meta_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        src_hdr_val       = 1'b0;
        src_src_ip        = '0;
        src_dst_ip        = '0;
        src_udp_hdr       = '0;
        src_timestamp     = '0;
        src_data_val      = 1'b0;
        src_data          = '0;
        src_data_last     = 1'b0;
        src_data_padbytes = '0;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_i("rst_hdr_rdy", int'(src_hdr_rdy), 0);
        check_i("rst_data_rdy", int'(src_data_rdy), 0);
        check_i("rst_data_val", int'(dst_data_val), 0);
        check_i("rst_meta_val", int'(dst_meta_val), 0);
        check_i("rst_len_err", int'(length_err), 0);
        check_w("rst_dst_data", dst_data, '0);
        check_i("rst_meta_len", int'(dst_meta_udp_len), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_i("hdr_rdy_after_rst", int'(src_hdr_rdy), 1);
        @(posedge clk);
        #1;

        // 72-byte UDP packet, single full payload word: tail spills into a drain word.
        w0 = n_words;
        send_pkt(1, 72, 64, 1'b0, 99);
        wait_idle();
        check_i("c1_words", n_words - w0, 2);
        check_i("c1_last_pad", last_pad_seen, 56);

        // 100-byte payload, last input word pad 28 -> output pad 20.
        w0 = n_words;
        send_pkt(2, 108, 100, 1'b0, 99);
        wait_idle();
        check_i("c2_words", n_words - w0, 2);
        check_i("c2_last_pad", last_pad_seen, 20);

        // Header only, with a payload word offered that must never be taken.
        w0 = n_words;
        d0 = n_dacc;
        src_data     = {DW{1'b1}};
        src_data_val = 1'b1;
        send_pkt(3, 8, 0, 1'b0, 99);
        wait_idle();
        check_i("c3_words", n_words - w0, 1);
        check_i("c3_last_pad", last_pad_seen, 56);
        check_i("c3_no_data_acc", n_dacc - d0, 0);
        src_data_val = 1'b0;
        check_i("len_err_clean", int'(length_err), 0);

        // Random backpressure on both outputs.
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int l;
            l = $urandom_range(0, 200);
            send_pkt(10 + i, 8 + l, l, 1'b1, 99);
        end
        wait_idle();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_i("len_err_after_random", int'(length_err), 0);

        // Header claims 64 payload bytes but 128 are sent.
        send_pkt(300, 72, 128, 1'b0, 99);
        wait_idle();
`ifdef UDP_TX_HDR_TO_STREAM_LEN_CHECK_EN
        check_i("len_err_set", int'(length_err), 1);
`else
        check_i("len_err_off", int'(length_err), 0);
`endif
        send_pkt(301, 80, 72, 1'b0, 99);
        wait_idle();
`ifdef UDP_TX_HDR_TO_STREAM_LEN_CHECK_EN
        check_i("len_err_sticky", int'(length_err), 1);
`else
        check_i("len_err_off_2", int'(length_err), 0);
`endif

        // Reset while in MID: drive header + first word of a 3-word payload, then reset.
        send_pkt(302, 200, 192, 1'b0, 1);
        rst = 1'b1;
        exp_q.delete();
        meta_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_i("midrst_data_val", int'(dst_data_val), 0);
        check_i("midrst_data_rdy", int'(src_data_rdy), 0);
        check_i("midrst_hdr_rdy", int'(src_hdr_rdy), 0);
        check_i("midrst_meta_val", int'(dst_meta_val), 0);
        check_w("midrst_dst_data", dst_data, '0);
        check_i("midrst_meta_len", int'(dst_meta_udp_len), 0);
        check_i("midrst_len_err", int'(length_err), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        n_last = n_hdr;
        n_meta = n_hdr;

        w0 = n_words;
        send_pkt(303, 138, 130, 1'b0, 99);
        wait_idle();
        check_i("post_rst_words", n_words - w0, 3);
        check_i("post_rst_last_pad", last_pad_seen, 54);
        check_i("queues_empty", exp_q.size() + meta_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_tx_hdr_to_stream.md
# udp_tx_hdr_to_stream

Sits directly downstream of the UDP TX NoC-input datapath in the UDP TX tile. Takes a parsed UDP header with IP addresses and timestamp, plus the payload stream. Emits the UDP packet as a byte-packed MAC-width stream with the 8-byte UDP header prepended to the payload. Emits a separate metadata handshake (IPs, UDP length, timestamp) for the IP TX stage.

## Interface
Parameters:
- DATA_W, 512, stream width in bits; multiple of 64
- DATA_BYTES, DATA_W/8, derived
- PADBYTES_W, $clog2(DATA_BYTES), derived

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_hdr_val / src_hdr_rdy  in/out  1  header handshake
- src_src_ip, src_dst_ip  in  32  IP addresses
- src_udp_hdr  in  64  udp_pkt_hdr (src_port, dst_port, length, chksum)
- src_timestamp  in  TRACKER_STATS_W  tracker_stats_struct
- src_data_val / src_data_rdy  in/out  1  payload handshake
- src_data  in  DATA_W  payload word, byte 0 at MSB
- src_data_last  in  1  final payload word
- src_data_padbytes  in  PADBYTES_W  invalid low bytes on last word
- dst_meta_val / dst_meta_rdy  out/in  1  metadata handshake
- dst_meta_src_ip, dst_meta_dst_ip  out  32
- dst_meta_udp_len  out  16  UDP length, header included
- dst_meta_timestamp  out  TRACKER_STATS_W
- dst_data_val / dst_data_rdy  out/in  1  output stream handshake
- dst_data  out  DATA_W
- dst_data_last  out  1
- dst_data_padbytes  out  PADBYTES_W
- length_err  out  1  sticky payload-length mismatch

## Operation
- States: IDLE, FIRST, MID, DRAIN, HDR_ONLY.
- IDLE: src_hdr_rdy = !meta_pending. On header accept:
  - register the header fields; set meta_pending.
  - go to HDR_ONLY if udp length ≤ 8, else FIRST.
- Metadata: dst_meta_val = meta_pending. Clear meta_pending on dst_meta_rdy. Metadata is independent of data progress.
- FIRST handshake:
  - src_data_rdy = dst_data_rdy and dst_data_val = src_data_val (combinational pass-through).
  - dst_data = {udp_hdr, src_data[DATA_W-1:64]}.
  - Register src_data[63:0] into carry.
- MID handshake: same as FIRST, but dst_data = {carry, src_data[DATA_W-1:64]}, then update carry.
- Last input word with padbytes p:
  - p ≥ 8: output is last, padbytes p−8; go to IDLE.
  - p < 8: output not last; go to DRAIN. A FIRST word with p < 8 also goes to DRAIN.
- DRAIN:
  - dst_data_val = 1, src_data_rdy = 0.
  - dst_data = {carry, zeros}, last = 1, padbytes = DATA_BYTES−8+p. Store p in a register.
  - Go to IDLE on dst_data_rdy.
- HDR_ONLY:
  - dst_data = {udp_hdr, zeros}, last = 1, padbytes = DATA_BYTES−8.
  - Consumes no payload. Go to IDLE on dst_data_rdy.
- Invalid output bytes are driven zero.
- Arithmetic: padbytes computed in PADBYTES_W+1 bits, then truncated. dst_meta_udp_len is passed through unmodified.

## Timing
- Reset values: state IDLE, meta_pending 0, carry 0, all *_val 0, src_hdr_rdy 0, src_data_rdy 0, length_err 0, dst data/meta fields 0.
- src_hdr_rdy rises in the first cycle after rst deasserts.
- Latency:
  - Data path: 0 cycles (combinational val/rdy) in FIRST/MID.
  - Metadata: valid 1 cycle after header accept.
- Next header is accepted no earlier than the cycle after both conditions hold:
  - the last output word handshook;
  - meta_pending is clear.
- If meta_rdy and a new header arrive in the same cycle, the header waits one cycle.
- src_data_val while in IDLE or HDR_ONLY is not accepted; the word is held upstream.
- Output fields are held stable while dst_data_val=1 and dst_data_rdy=0.
- rst mid-packet: immediate return to reset values. Partial packet is discarded; upstream is reset alongside.

## Configuration
- UDP_TX_HDR_TO_STREAM_LEN_CHECK_EN defined:
  - Count accepted payload bytes (16-bit).
  - On the last payload word, compare the count with udp length−8.
  - A mismatch sets length_err, sticky until rst.
  - udp length < 8 also sets it.
  - Stream behaviour is unchanged.
- Undefined: no counter; length_err tied 0.

## Structure
- In shared udp package: udp_pkt_hdr, UDP_HDR_BYTES (8), UDP_HDR_W (64).
- From tracker_pkg: tracker_stats_struct.
- Natural split: udp_tx_hdr_to_stream_ctrl (FSM, handshakes) plus the top-level datapath (carry, muxes, padbytes, optional counter).

## Test plan
- Length 8+64, one payload word (p=0), DATA_W=512: outputs 2 words; second holds payload bytes 56–63 with last=1, padbytes=56.
- Length 8+100, two words (last p=28): 2 output words; last padbytes=20, bytes shifted by 8.
- Length 8 header-only: one word, hdr at MSB, last=1, padbytes=56; src_data_rdy stays 0.
- Random dst_data_rdy/dst_meta_rdy backpressure over 200 packets: payload bytes match, meta in order, no header accepted before the prior meta handshakes.
- With the macro on: length 8+64 but 2 full words sent -> length_err=1 after the last word and stays 1. With the macro off: length_err=0.
- rst asserted mid-MID state: all outputs at reset values next cycle; next packet is correct.
